// File: rtl/snax_simbacore_launch_ctrl.sv
// Launch controller between the SNAX CSR manager and SimbaCore: buffers one pending config,
// issues it to the core when idle, and tracks completion through the core busy flag.
module snax_simbacore_launch_ctrl #(
    parameter int unsigned RegRWCount   = 6,
    parameter int unsigned RegROCount   = 4,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned ConfigCount  = 5,
    parameter int unsigned BusyTimeout  = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [RegRWCount*RegDataWidth-1:0]   csr_reg_set_i,
    input  logic                                 csr_reg_set_valid_i,
    output logic                                 csr_reg_set_ready_o,
    output logic [RegROCount*RegDataWidth-1:0]   csr_reg_ro_set_o,
    output logic [ConfigCount*RegDataWidth-1:0]  cfg_o,
    output logic                                 cfg_valid_o,
    input  logic                                 cfg_ready_i,
    input  logic                                 core_busy_i,
    input  logic [RegDataWidth-1:0]              core_cnt0_i,
    input  logic [RegDataWidth-1:0]              core_cnt1_i
);

    localparam int unsigned CfgWidth    = ConfigCount * RegDataWidth;
    localparam int unsigned RunCntWidth = $clog2(BusyTimeout + 1);
    localparam int unsigned StartBitIdx = (RegRWCount - 1) * RegDataWidth;
    localparam logic [RunCntWidth-1:0] RunCntMax = RunCntWidth'(BusyTimeout);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRun
    } state_e;

    state_e                   state_q, state_d;
    logic                     pend_valid_q, pend_valid_d;
    logic [CfgWidth-1:0]      pend_q, pend_d;
    logic [CfgWidth-1:0]      cfg_q, cfg_d;
    logic                     cfg_valid_q, cfg_valid_d;
    logic [RegDataWidth-1:0]  perf_cnt_q, perf_cnt_d;
    logic [15:0]              job_cnt_q, job_cnt_d;
    logic                     seen_busy_q, seen_busy_d;
    logic [RunCntWidth-1:0]   run_cnt_q, run_cnt_d;

    logic                     accept;
    logic                     run_exit;
    logic [RegDataWidth-1:0]  ro_status;

    assign accept = csr_reg_set_valid_i && !pend_valid_q;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        cfg_d        = cfg_q;
        cfg_valid_d  = cfg_valid_q;
        perf_cnt_d   = perf_cnt_q;
        job_cnt_d    = job_cnt_q;
        seen_busy_d  = seen_busy_q;
        run_cnt_d    = run_cnt_q;
        run_exit     = 1'b0;

        // Bundles without the start bit are consumed and dropped.
        if (accept && csr_reg_set_i[StartBitIdx]) begin
            pend_d       = csr_reg_set_i[CfgWidth-1:0];
            pend_valid_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (pend_valid_q) begin
                    state_d     = StIssue;
                    cfg_valid_d = 1'b1;
                    cfg_d       = pend_q;
                end
            end
            StIssue: begin
                if (cfg_ready_i) begin
                    cfg_valid_d  = 1'b0;
                    pend_valid_d = 1'b0;
                    perf_cnt_d   = '0;
                    seen_busy_d  = 1'b0;
                    run_cnt_d    = '0;
                    state_d      = StRun;
                end
            end
            StRun: begin
                perf_cnt_d  = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + RegDataWidth'(1);
                run_cnt_d   = (run_cnt_q == RunCntMax) ? run_cnt_q : run_cnt_q + RunCntWidth'(1);
                seen_busy_d = seen_busy_q | core_busy_i;
                // Timeout counts the current cycle, so a zero-work job spends BusyTimeout cycles here.
                run_exit = (seen_busy_q && !core_busy_i) || (!seen_busy_d && run_cnt_d == RunCntMax);
                if (run_exit) begin
                    job_cnt_d = job_cnt_q + 16'd1;
                    if (pend_valid_q) begin
                        state_d     = StIssue;
                        cfg_valid_d = 1'b1;
                        cfg_d       = pend_q;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            cfg_q        <= '0;
            cfg_valid_q  <= 1'b0;
            perf_cnt_q   <= '0;
            job_cnt_q    <= '0;
            seen_busy_q  <= 1'b0;
            run_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            cfg_q        <= cfg_d;
            cfg_valid_q  <= cfg_valid_d;
            perf_cnt_q   <= perf_cnt_d;
            job_cnt_q    <= job_cnt_d;
            seen_busy_q  <= seen_busy_d;
            run_cnt_q    <= run_cnt_d;
        end
    end

    always_comb begin
        ro_status        = '0;
        ro_status[0]     = (state_q != StIdle) || pend_valid_q;
        ro_status[1]     = pend_valid_q;
        ro_status[31:16] = job_cnt_q;
    end

    assign csr_reg_set_ready_o = !pend_valid_q;
    assign cfg_o               = cfg_q;
    assign cfg_valid_o         = cfg_valid_q;
    assign csr_reg_ro_set_o    = {core_cnt1_i, core_cnt0_i, perf_cnt_q, ro_status};

endmodule

// File: tb/tb_snax_simbacore_launch_ctrl.sv
// Scoreboard bench for snax_simbacore_launch_ctrl: issued configs are checked against a queue
// filled at CSR write time; each scenario task checks status, counters and handshake timing.
module tb_snax_simbacore_launch_ctrl;

    localparam int RW = 6;
    localparam int RO = 4;
    localparam int DW = 32;
    localparam int CC = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [RW*DW-1:0]  csr_set = '0;
    logic              csr_valid = 1'b0;
    logic              csr_ready;
    logic [RO*DW-1:0]  ro;
    logic [CC*DW-1:0]  cfg;
    logic              cfg_valid;
    logic              cfg_ready = 1'b0;
    logic              core_busy = 1'b0;
    logic [DW-1:0]     cnt0 = '0;
    logic [DW-1:0]     cnt1 = '0;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    int vcyc = 0;
    int exp_jobs = 0;
    logic [CC*DW-1:0] exp_q[$];
    logic [CC*DW-1:0] mon_exp;
    logic [CC*DW-1:0] last_cfg = '0;

    snax_simbacore_launch_ctrl dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .csr_reg_set_i       (csr_set),
        .csr_reg_set_valid_i (csr_valid),
        .csr_reg_set_ready_o (csr_ready),
        .csr_reg_ro_set_o    (ro),
        .cfg_o               (cfg),
        .cfg_valid_o         (cfg_valid),
        .cfg_ready_i         (cfg_ready),
        .core_busy_i         (core_busy),
        .core_cnt0_i         (cnt0),
        .core_cnt1_i         (cnt1)
    );

    always #5 clk = ~clk;

    // Config handshake monitor: pops the scoreboard on every accepted config.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_valid) vcyc++;
            if (cfg_valid && cfg_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL cfg_unexpected: cfg_o=%h issued with no job queued", cfg);
                end else begin
                    mon_exp = exp_q.pop_front();
                    last_cfg = mon_exp;
                    if (cfg !== mon_exp) begin
                        bad++;
                        $display("FAIL cfg_data: cfg_o=%h want %h", cfg, mon_exp);
                    end
                end
                hs_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic start, input logic [CC*DW-1:0] c);
        int n;
        csr_set = {{(DW - 1){1'b0}}, start, c};
        csr_valid = 1'b1;
        n = 0;
        while (csr_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (csr_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: csr_reg_set_ready_o=%b want 1", csr_ready);
        end else if (start) begin
            exp_q.push_back(c);
        end
        tick();
        csr_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_cnt < target && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (hs_cnt != target) begin
            bad++;
            $display("FAIL wait_hs: handshakes=%0d want %0d", hs_cnt, target);
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (csr_ready !== 1'b1 || cfg_valid !== 1'b0 || cfg !== '0 || ro[63:0] !== 64'h0) begin
            bad++;
            $display("FAIL reset_vals: ready=%b valid=%b cfg=%h ro=%h want 1 0 0 0",
                     csr_ready, cfg_valid, cfg, ro[63:0]);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (csr_ready !== 1'b1 || cfg_valid !== 1'b0 || ro[63:0] !== 64'h0) begin
            bad++;
            $display("FAIL reset_idle: ready=%b valid=%b ro=%h want 1 0 0",
                     csr_ready, cfg_valid, ro[63:0]);
        end
    endtask

    task automatic test_passthrough();
        cnt0 = $urandom;
        cnt1 = $urandom;
        #1;
        total++;
        if (ro[95:64] !== cnt0 || ro[127:96] !== cnt1) begin
            bad++;
            $display("FAIL passthrough: ro2=%h ro3=%h want %h %h", ro[95:64], ro[127:96], cnt0, cnt1);
        end
    endtask

    task automatic test_single_job();
        logic [CC*DW-1:0] c;
        int v0;
        c = {32'd128, 32'd4, 32'd32, 32'd64, 32'd1};
        cfg_ready = 1'b1;
        core_busy = 1'b0;
        v0 = vcyc;
        send(1'b1, c);
        wait_hs(1);
        tick();
        core_busy = 1'b1;
        repeat (10) tick();
        core_busy = 1'b0;
        total++;
        if (ro[0] !== 1'b1) begin
            bad++;
            $display("FAIL single_running: ro0.busy=%b want 1", ro[0]);
        end
        tick();
        exp_jobs = 1;
        total++;
        if (vcyc - v0 != 1) begin
            bad++;
            $display("FAIL single_valid_len: cfg_valid cycles=%0d want 1", vcyc - v0);
        end
        total++;
        if (ro[31:0] !== {16'(exp_jobs), 16'h0} || ro[63:32] !== 32'd12) begin
            bad++;
            $display("FAIL single_status: ro0=%h ro1=%0d want %h 12",
                     ro[31:0], ro[63:32], {16'(exp_jobs), 16'h0});
        end
        total++;
        if (cfg !== c || cfg_valid !== 1'b0 || csr_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_hold: cfg=%h valid=%b ready=%b want %h 0 1",
                     cfg, cfg_valid, csr_ready, c);
        end
    endtask

    task automatic test_issue_stall();
        logic [CC*DW-1:0] c;
        c = {32'hA5A5_0004, 32'h1234_5678, 32'd3, 32'd2, 32'd1};
        cfg_ready = 1'b0;
        send(1'b1, c);
        tick();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (cfg_valid !== 1'b1 || cfg !== c || csr_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_cycle%0d: valid=%b cfg=%h ready=%b want 1 %h 0",
                         i, cfg_valid, cfg, csr_ready, c);
            end
            tick();
        end
        total++;
        if (hs_cnt != 1 || cfg_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_held: handshakes=%0d valid=%b want 1 1", hs_cnt, cfg_valid);
        end
        cfg_ready = 1'b1;
        wait_hs(2);
        core_busy = 1'b1;
        repeat (3) tick();
        core_busy = 1'b0;
        tick();
        exp_jobs = 2;
        total++;
        if (ro[31:0] !== {16'(exp_jobs), 16'h0} || ro[63:32] !== 32'd4) begin
            bad++;
            $display("FAIL stall_status: ro0=%h ro1=%0d want %h 4",
                     ro[31:0], ro[63:32], {16'(exp_jobs), 16'h0});
        end
    endtask

    task automatic test_back_to_back();
        logic [CC*DW-1:0] ca;
        logic [CC*DW-1:0] cb;
        ca = {32'd50, 32'd40, 32'd30, 32'd20, 32'd10};
        cb = {32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h7};
        cfg_ready = 1'b1;
        send(1'b1, ca);
        wait_hs(3);
        core_busy = 1'b1;
        send(1'b1, cb);
        total++;
        if (csr_ready !== 1'b0 || ro[31:0] !== {16'(exp_jobs), 16'h3}) begin
            bad++;
            $display("FAIL b2b_queued: ready=%b ro0=%h want 0 %h",
                     csr_ready, ro[31:0], {16'(exp_jobs), 16'h3});
        end
        tick();
        core_busy = 1'b0;
        tick();
        exp_jobs = 3;
        total++;
        if (cfg_valid !== 1'b1 || cfg !== cb) begin
            bad++;
            $display("FAIL b2b_no_bubble: valid=%b cfg=%h want 1 %h", cfg_valid, cfg, cb);
        end
        total++;
        if (ro[31:0] !== {16'(exp_jobs), 16'h3} || ro[63:32] !== 32'd3) begin
            bad++;
            $display("FAIL b2b_mid_status: ro0=%h ro1=%0d want %h 3",
                     ro[31:0], ro[63:32], {16'(exp_jobs), 16'h3});
        end
        wait_hs(4);
        core_busy = 1'b1;
        repeat (2) tick();
        core_busy = 1'b0;
        tick();
        exp_jobs = 4;
        total++;
        if (ro[31:0] !== {16'(exp_jobs), 16'h0} || ro[63:32] !== 32'd3 || csr_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_end: ro0=%h ro1=%0d ready=%b want %h 3 1",
                     ro[31:0], ro[63:32], csr_ready, {16'(exp_jobs), 16'h0});
        end
    endtask

    task automatic test_timeout();
        logic [CC*DW-1:0] c;
        c = {32'd9, 32'd8, 32'd7, 32'd6, 32'd5};
        cfg_ready = 1'b1;
        core_busy = 1'b0;
        send(1'b1, c);
        wait_hs(5);
        repeat (15) tick();
        total++;
        if (ro[0] !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: ro0.busy=%b want 1 on 16th run cycle", ro[0]);
        end
        tick();
        exp_jobs = 5;
        total++;
        if (ro[31:0] !== {16'(exp_jobs), 16'h0} || ro[63:32] !== 32'd16) begin
            bad++;
            $display("FAIL timeout_end: ro0=%h ro1=%0d want %h 16",
                     ro[31:0], ro[63:32], {16'(exp_jobs), 16'h0});
        end
    endtask

    task automatic test_start_zero();
        logic [CC*DW-1:0] c;
        c = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        send(1'b0, c);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cfg_valid !== 1'b0 || csr_ready !== 1'b1 || ro[31:0] !== {16'(exp_jobs), 16'h0}) begin
                bad++;
                $display("FAIL start0_cycle%0d: valid=%b ready=%b ro0=%h want 0 1 %h",
                         i, cfg_valid, csr_ready, ro[31:0], {16'(exp_jobs), 16'h0});
            end
            tick();
        end
        total++;
        if (cfg !== last_cfg) begin
            bad++;
            $display("FAIL start0_cfg_hold: cfg=%h want %h", cfg, last_cfg);
        end
    endtask

    task automatic test_reset_mid_run();
        cfg_ready = 1'b1;
        send(1'b1, {32'd11, 32'd12, 32'd13, 32'd14, 32'd15});
        wait_hs(6);
        core_busy = 1'b1;
        send(1'b1, {32'd21, 32'd22, 32'd23, 32'd24, 32'd25});
        total++;
        if (ro[31:0] !== {16'(exp_jobs), 16'h3}) begin
            bad++;
            $display("FAIL rst_pre: ro0=%h want %h", ro[31:0], {16'(exp_jobs), 16'h3});
        end
        #2 rst_n = 1'b0;
        #1;
        exp_jobs = 0;
        exp_q.delete();
        total++;
        if (csr_ready !== 1'b1 || cfg_valid !== 1'b0 || cfg !== '0 || ro[63:0] !== 64'h0) begin
            bad++;
            $display("FAIL rst_run: ready=%b valid=%b cfg=%h ro=%h want 1 0 0 0",
                     csr_ready, cfg_valid, cfg, ro[63:0]);
        end
        core_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (cfg_valid !== 1'b0 || ro[31:0] !== 32'h0) begin
            bad++;
            $display("FAIL rst_job_lost: valid=%b ro0=%h want 0 0", cfg_valid, ro[31:0]);
        end
        cfg_ready = 1'b0;
        send(1'b1, {32'd31, 32'd32, 32'd33, 32'd34, 32'd35});
        tick();
        total++;
        if (cfg_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_issue_pre: valid=%b want 1", cfg_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        total++;
        if (cfg_valid !== 1'b0 || cfg !== '0 || csr_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_issue: valid=%b cfg=%h ready=%b want 0 0 1", cfg_valid, cfg, csr_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_single_job();
        test_issue_stall();
        test_back_to_back();
        test_timeout();
        test_start_zero();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snax_simbacore_launch_ctrl.md
Name: snax_simbacore_launch_ctrl

Overview:
Job launch controller between the SNAX CSR manager and the SimbaCore accelerator. It buffers one pending configuration written through the CSR interface and issues it to the core's config handshake once the core is idle. It then tracks job completion from the core's busy flag and exposes status, a per-job cycle counter and the core's counters as read-only CSRs.

Parameters:
RegRWCount, 6, number of RW CSRs; index RegRWCount-1 is the start register
RegROCount, 4, number of RO CSRs (fixed usage below; must be 4)
RegDataWidth, 32, CSR width
ConfigCount, 5, config words forwarded to core (mode, seqLen, dModel, dtRank, dInner = csr[0..4])
BusyTimeout, 16, RUN cycles without core busy before a job is treated as zero-work

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
csr_reg_set_i  in  RegRWCount*RegDataWidth  CSR write bundle from CSR manager
csr_reg_set_valid_i  in  1  CSR bundle valid
csr_reg_set_ready_o  out  1  CSR bundle ready
csr_reg_ro_set_o  out  RegROCount*RegDataWidth  RO CSRs
cfg_o  out  ConfigCount*RegDataWidth  config words to core io_config_bits_*
cfg_valid_o  out  1  to core io_config_valid
cfg_ready_i  in  1  from core io_config_ready
core_busy_i  in  1  core io_busy_o
core_cnt0_i  in  RegDataWidth  core osCoreTileCnt
core_cnt1_i  in  RegDataWidth  core suCoreOutCnt

Behaviour:
- Reset: state=IDLE, pend_valid=0, pend data=0, perf_cnt=0, job_cnt=0, seen_busy=0, run_cnt=0; outputs: csr_reg_set_ready_o=1, cfg_valid_o=0, cfg_o=0.
- Pending buffer (1 deep): csr_reg_set_ready_o = !pend_valid (registered only; no combinational path from cfg_ready_i or valid_i).
- Upstream accept (valid&&ready): if csr[RegRWCount-1][0]=1, capture csr[0..ConfigCount-1] into pend, set pend_valid next cycle. If the start bit is 0, the bundle is accepted and dropped with no state change.
- FSM states IDLE, ISSUE, RUN:
  - IDLE: if pend_valid, go to ISSUE.
  - ISSUE: cfg_valid_o=1, cfg_o=pend data. Both are held stable until cfg_ready_i. On handshake: pend_valid<=0, perf_cnt<=0, seen_busy<=0, run_cnt<=0, go to RUN.
  - RUN: perf_cnt+=1 per cycle, saturating at all-ones. run_cnt+=1, saturating at BusyTimeout. seen_busy<=1 when core_busy_i=1.
  - RUN exit: when (seen_busy && !core_busy_i) or (!seen_busy && run_cnt==BusyTimeout). On exit job_cnt+=1 (16-bit, wraps 0xFFFF->0). Next state is ISSUE if pend_valid else IDLE. Back-to-back jobs have no IDLE bubble.
- cfg_o outside ISSUE: holds last issued value.
- Next job: may be queued during ISSUE's predecessor RUN. A queued job cannot be overwritten; upstream stalls while pend_valid=1.
- RO CSRs:
  - [0]: bit0 busy = (state!=IDLE)||pend_valid; bit1 pend_valid; bits15:2 = 0; bits31:16 job_cnt.
  - [1]: perf_cnt, held after job end until the next launch.
  - [2]: core_cnt0_i, combinational pass-through.
  - [3]: core_cnt1_i, combinational pass-through.
- Reset mid-operation: all state cleared asynchronously, any pending job lost, cfg_valid_o drops immediately.
- Simultaneous events:
  - Upstream accept and RUN exit in the same cycle: the new pend is not visible until the next cycle, so the FSM goes to IDLE, then ISSUE one cycle later.
  - core_busy_i=1 already asserted on the first RUN cycle: counts as seen.

Test Plan:
- Reset then write start=1, cfg=(1,64,32,4,128); hold cfg_ready_i=1; core busy for 10 cycles starting 1 cycle after handshake -> cfg_valid_o high exactly 1 cycle carrying those values; ro[0]=0x0001_0000 after done; ro[1]=12.
- Hold cfg_ready_i=0 for 5 cycles while in ISSUE -> cfg_valid_o and cfg_o stable all 5 cycles; csr_reg_set_ready_o=0; handshake on cycle 6.
- Queue a second job during RUN of the first -> ready_o drops to 0; second cfg_valid_o asserts in the cycle after RUN exit with no IDLE; job_cnt=2 at end.
- Core never asserts busy -> RUN exits after 16 cycles; ro[1]=16; job_cnt increments.
- Write with start bit 0 -> accepted (ready=1), cfg_valid_o stays 0, ro[0]=0.
- Assert rst_ni low during RUN with a pending job -> all outputs at reset values immediately; job_cnt=0, ready_o=1.
